// File: rtl/cla_accum_seq.sv
// Burst accumulator: drives an external combinational CLA adder with the running
// total and each accepted operand, and counts the carry-outs seen during the burst.
module cla_accum_seq #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] add_a_o,
    output logic [DATA_W-1:0] add_b_o,
    output logic              add_cin_o,
    input  logic [DATA_W-1:0] add_sum_i,
    input  logic              add_cout_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_sum_o,
    output logic [CNT_W-1:0]  out_carries_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  carries_q, carries_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            carries_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carries_q <= carries_d;
            cnt_q     <= cnt_d;
        end
    end

    // Handshakes: a beat transfers on a cycle where valid & ready are both high;
    // valid never waits on ready, and ready here comes from state only.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carries_d = carries_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d     = '0;
                    carries_d = '0;
                    if (len_i != '0) begin
                        cnt_d   = len_i;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid_i) begin
                    acc_d = add_sum_i;
                    if (add_cout_i && (carries_q != '1))
                        carries_d = carries_q + CNT_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign add_a_o       = acc_q;
    assign add_b_o       = in_data_i;
    assign add_cin_o     = 1'b0;
    assign in_ready_o    = (state_q == ACCUM);
    assign out_valid_o   = (state_q == DONE);
    assign out_sum_o     = (state_q == DONE) ? acc_q : '0;
    assign out_carries_o = (state_q == DONE) ? carries_q : '0;
    assign busy_o        = (state_q != IDLE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_cla_accum_seq.sv
// Bench for cla_accum_seq: directed bursts plus randomized bursts, checked against
// a plain-arithmetic model of the burst sum and its overflow count.
module tb_cla_accum_seq;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] len_i;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic [DW-1:0] add_a_o;
    logic [DW-1:0] add_b_o;
    logic          add_cin_o;
    logic [DW-1:0] add_sum_i;
    logic          add_cout_i;
    logic          out_valid_o;
    logic [DW-1:0] out_sum_o;
    logic [CW-1:0] out_carries_o;
    logic          out_ready_i;
    logic          busy_o;
    logic [1:0]    state_o;

    cla_accum_seq #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .len_i        (len_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .add_a_o      (add_a_o),
        .add_b_o      (add_b_o),
        .add_cin_o    (add_cin_o),
        .add_sum_i    (add_sum_i),
        .add_cout_i   (add_cout_i),
        .out_valid_o  (out_valid_o),
        .out_sum_o    (out_sum_o),
        .out_carries_o(out_carries_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .state_o      (state_o)
    );

    // External 8-bit adder stand-in
    logic [DW:0] add_full;
    assign add_full   = {1'b0, add_a_o} + {1'b0, add_b_o} + {{DW{1'b0}}, add_cin_o};
    assign add_sum_i  = add_full[DW-1:0];
    assign add_cout_i = add_full[DW];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [CW+DW-1:0] exp_q[$];
    int ops[$];
    int gaps[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: total of the operands mod 256, overflow counted whenever the
    // true running total crosses another multiple of 256, capped at 15.
    task automatic model_push(input int n);
        int total = 0;
        int car = 0;
        for (int i = 0; i < n; i++) begin
            if ((total % 256) + ops[i] >= 256 && car < 15) car++;
            total = total + ops[i];
        end
        exp_q.push_back({car[CW-1:0], total[DW-1:0]});
    endtask

    task automatic set_ops(input int n, input int val, input int gapmax);
        ops.delete();
        gaps.delete();
        for (int i = 0; i < n; i++) begin
            ops.push_back((val < 0) ? int'($urandom_range(0, 255)) : val);
            gaps.push_back(int'($urandom_range(0, gapmax)));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic collect(input int hold);
        int w = 0;
        logic [CW+DW-1:0] e;
        while (!out_valid_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("done_latency", w, 0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("out_sum", int'(out_sum_o), int'(e[DW-1:0]));
        check("out_carries", int'(out_carries_o), int'(e[CW+DW-1:DW]));
        for (int h = 0; h < hold; h++) begin
            out_ready_i = 1'b0;
            start_i     = 1'b1;
            in_valid_i  = 1'b1;
            in_data_i   = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("hold_valid", int'(out_valid_o), 1);
            check("hold_sum", int'(out_sum_o), int'(e[DW-1:0]));
            check("hold_carries", int'(out_carries_o), int'(e[CW+DW-1:DW]));
            check("done_ready", int'(in_ready_o), 0);
        end
        in_valid_i  = 1'b0;
        start_i     = 1'b1;
        len_i       = 4'd3;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        check("ack_valid_drop", int'(out_valid_o), 0);
        check("ack_idle_busy", int'(busy_o), 0);
    endtask

    task automatic run_burst(input int n, input int hold);
        int run = 0;
        model_push(n);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = n[CW-1:0];
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", int'(busy_o), 1);
        if (n != 0) check("ready_latency", int'(in_ready_o), 1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid_i = 1'b0;
                in_data_i  = 8'($urandom_range(0, 255));
                @(negedge clk);
                check("stall_ready", int'(in_ready_o), 1);
                check("stall_acc", int'(add_a_o), run % 256);
            end
            in_valid_i = 1'b1;
            in_data_i  = ops[i][DW-1:0];
            #1;
            check("add_a", int'(add_a_o), run % 256);
            check("add_b", int'(add_b_o), ops[i]);
            check("add_cin", int'(add_cin_o), 0);
            @(negedge clk);
            in_valid_i = 1'b0;
            run = run + ops[i];
        end
        collect(hold);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        len_i       = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready_o), 0);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_out_sum", int'(out_sum_o), 0);
        check("rst_out_carries", int'(out_carries_o), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(busy_o), 0);
        in_valid_i = 1'b1;
        #1;
        check("idle_ready", int'(in_ready_o), 0);
        in_valid_i = 1'b0;

        // 1: three operands back-to-back
        ops = '{8'h10, 8'h20, 8'h30};
        gaps = '{0, 0, 0};
        run_burst(3, 0);

        // 2: single wrap, then two wraps
        ops = '{8'hFF, 8'h02};
        gaps = '{0, 0};
        run_burst(2, 1);
        set_ops(4, 8'h80, 0);
        run_burst(4, 0);

        // 3: longest burst of 0xFF, twice
        set_ops(15, 8'hFF, 0);
        run_burst(15, 0);
        set_ops(15, 8'hFF, 1);
        run_burst(15, 2);

        // 4: empty burst with a long hold and ignored starts
        set_ops(0, 0, 0);
        run_burst(0, 5);

        // 5: stalls between beats
        ops = '{8'h11, 8'h22, 8'h33};
        gaps = '{0, 2, 4};
        run_burst(3, 2);
        in_valid_i = 1'b1;
        #1;
        check("idle_ready_after", int'(in_ready_o), 0);
        in_valid_i = 1'b0;

        // 6: reset after two of four beats
        @(negedge clk);
        start_i = 1'b1;
        len_i   = 4'd4;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'h40;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_out_valid", int'(out_valid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        ops = '{8'h05};
        gaps = '{0};
        run_burst(1, 0);

        // randomized bursts
        for (int k = 0; k < 30; k++) begin
            int n;
            n = int'($urandom_range(0, 15));
            set_ops(n, -1, 3);
            run_burst(n, int'($urandom_range(0, 3)));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
